// File: rtl/keypad_entry_ctrl_if.sv
// Entry handshake bundle: the controller presents a BCD entry and its length,
// and downstream logic takes it with valid/ready.
interface keypad_entry_ctrl_if #(
    parameter int DIGITS = 4,
    parameter int LEN_W  = 3
) ();
    logic [4*DIGITS-1:0] entry_data;
    logic [LEN_W-1:0]    entry_len;
    logic                entry_valid;
    logic                entry_ready;

    modport master (output entry_data, entry_len, entry_valid, input entry_ready);
    modport slave  (input entry_data, entry_len, entry_valid, output entry_ready);
endinterface

// File: rtl/keypad_entry_ctrl.sv
// Turns per-key press pulses from a 4x4 scanner into complete numeric entries.
// The entry FSM has an inactivity timeout, and each finished entry is held until downstream accepts it.
module keypad_entry_ctrl #(
    parameter int DIGITS      = 4,
    parameter int LEN_W       = 3,
    parameter int TIMEOUT_CYC = 12000000,
    parameter int TO_W        = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [15:0]          key_pulse,
    keypad_entry_ctrl_if.master  ent,
    output logic                 busy,
    output logic                 err_pulse,
    output logic                 timeout_pulse
);
    localparam int DW = 4 * DIGITS;

    typedef enum logic [1:0] {IDLE, ENTRY, HOLD} state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] idx;
    } key_t;

    state_t          state_q, state_n;
    logic [DW-1:0]   data_q, data_n, data_shl, data_shr;
    logic [LEN_W-1:0] len_q, len_n;
    logic [TO_W-1:0] cnt_q, cnt_n;
    logic            valid_q, valid_n, err_n, to_n;
    key_t            key;
    logic            key_any, is_dig, is_bs, is_ent, is_clr;

    // Scan from the top so the lowest set bit is the last one written and wins.
    always_comb begin
        key = '0;
        for (int i = 15; i >= 0; i--) begin
            if (key_pulse[i]) begin
                key.vld = 1'b1;
                key.idx = 4'(i);
            end
        end
    end

    assign key_any = key.vld && (key.idx <= 4'd12);
    assign is_dig  = key.vld && (key.idx <= 4'd9);
    assign is_bs   = key.vld && (key.idx == 4'd10);
    assign is_ent  = key.vld && (key.idx == 4'd11);
    assign is_clr  = key.vld && (key.idx == 4'd12);

    // The concatenation is wider than DW. The cast keeps the low DW bits, so the
    // oldest digit falls off the top. This also holds when DIGITS is 1.
    assign data_shl = DW'({data_q, key.idx});
    assign data_shr = data_q >> 4;

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        len_n   = len_q;
        cnt_n   = cnt_q;
        valid_n = valid_q;
        err_n   = 1'b0;
        to_n    = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_n = '0;
                if (is_dig) begin
                    data_n  = data_shl;
                    len_n   = LEN_W'(1);
                    state_n = ENTRY;
                end else if (is_ent) begin
                    err_n = 1'b1;
                end
            end
            ENTRY: begin
                if (key_any) begin
                    cnt_n = '0;
                    if (is_dig) begin
                        if (len_q == LEN_W'(DIGITS)) begin
                            err_n = 1'b1;
                        end else begin
                            data_n = data_shl;
                            len_n  = len_q + LEN_W'(1);
                        end
                    end else if (is_bs) begin
                        data_n = data_shr;
                        len_n  = len_q - LEN_W'(1);
                        if (len_q == LEN_W'(1)) state_n = IDLE;
                    end else if (is_clr) begin
                        data_n  = '0;
                        len_n   = '0;
                        state_n = IDLE;
                    end else begin
                        valid_n = 1'b1;
                        state_n = HOLD;
                    end
                end else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
                    data_n  = '0;
                    len_n   = '0;
                    cnt_n   = '0;
                    to_n    = 1'b1;
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt_q + TO_W'(1);
                end
            end
            HOLD: begin
                // Acceptance wins over any key arriving in the same cycle; that key is dropped.
                if (valid_q && ent.entry_ready) begin
                    valid_n = 1'b0;
                    data_n  = '0;
                    len_n   = '0;
                    state_n = IDLE;
                end else if (key_any) begin
                    err_n = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                data_n  = '0;
                len_n   = '0;
                cnt_n   = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            data_q        <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
            valid_q       <= 1'b0;
            busy          <= 1'b0;
            err_pulse     <= 1'b0;
            timeout_pulse <= 1'b0;
        end else begin
            state_q       <= state_n;
            data_q        <= data_n;
            len_q         <= len_n;
            cnt_q         <= cnt_n;
            valid_q       <= valid_n;
            busy          <= (state_n != IDLE);
            err_pulse     <= err_n;
            timeout_pulse <= to_n;
        end
    end

    assign ent.entry_data  = data_q;
    assign ent.entry_len   = len_q;
    assign ent.entry_valid = valid_q;
endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Bench for keypad_entry_ctrl: directed scenarios plus random traffic. Both are
// checked against a digit-queue reference model.
module tb_keypad_entry_ctrl;
    localparam int D  = 4;
    localparam int LW = 3;
    localparam int T  = 100;
    localparam int TW = 7;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] key_pulse = '0;
    logic        busy, err_pulse, timeout_pulse;

    keypad_entry_ctrl_if #(.DIGITS(D), .LEN_W(LW)) ent ();

    keypad_entry_ctrl #(.DIGITS(D), .LEN_W(LW), .TIMEOUT_CYC(T), .TO_W(TW)) dut (
        .clk           (clk),
        .rst           (rst),
        .key_pulse     (key_pulse),
        .ent           (ent.master),
        .busy          (busy),
        .err_pulse     (err_pulse),
        .timeout_pulse (timeout_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: the queue holds the digits in entry order, so the most recent digit is last.
    int q[$];
    bit m_hold = 0;
    int m_idle = 0;
    bit m_err = 0, m_to = 0;

    function automatic int lowest(input logic [15:0] kp);
        for (int i = 0; i < 16; i++) if (kp[i]) return i;
        return -1;
    endfunction

    function automatic logic [15:0] m_data();
        logic [15:0] d = '0;
        foreach (q[i]) d = (d << 4) | 16'(q[i]);
        return d;
    endfunction

    task automatic model(input logic [15:0] kp, input logic rdy, input logic r);
        int k = lowest(kp);
        bit real_key = (k >= 0) && (k <= 12);
        m_err = 0;
        m_to  = 0;
        if (r) begin
            q.delete(); m_hold = 0; m_idle = 0;
        end else if (m_hold) begin
            if (rdy) begin
                m_hold = 0; q.delete();
            end else if (real_key) m_err = 1;
        end else if (q.size() == 0) begin
            m_idle = 0;
            if (k >= 0 && k <= 9) q.push_back(k);
            else if (k == 11) m_err = 1;
        end else if (real_key) begin
            m_idle = 0;
            if (k <= 9) begin
                if (q.size() < D) q.push_back(k); else m_err = 1;
            end else if (k == 10) void'(q.pop_back());
            else if (k == 12) q.delete();
            else m_hold = 1;
        end else if (m_idle == T - 1) begin
            q.delete(); m_idle = 0; m_to = 1;
        end else m_idle++;
    endtask

    task automatic step(input logic [15:0] kp, input logic rdy = 1'b0, input logic r = 1'b0);
        key_pulse = kp;
        ent.entry_ready = rdy;
        rst = r;
        @(posedge clk);
        model(kp, rdy, r);
        #1;
        chk("data",  32'(ent.entry_data), 32'(m_data()));
        chk("len",   32'(ent.entry_len), 32'(q.size()));
        chk("valid", 32'(ent.entry_valid), 32'(m_hold));
        chk("busy",  32'(busy), 32'(m_hold || q.size() > 0));
        chk("err",   32'(err_pulse), 32'(m_err));
        chk("to",    32'(timeout_pulse), 32'(m_to));
        key_pulse = '0;
        ent.entry_ready = 1'b0;
        rst = 1'b0;
    endtask

    function automatic logic [15:0] kb(input int i);
        logic [15:0] one = 16'h1;
        return one << i;
    endfunction

    initial begin
        int k;
        logic [15:0] kp;
        ent.entry_ready = 1'b0;
        step(16'h0, 1'b0, 1'b1);
        chk("rst_len", 32'(ent.entry_len), 32'd0);

        // 1,2,3, enter, then ready stays low while the entry waits, then one ready pulse
        step(kb(1)); step(kb(2)); step(kb(3));
        chk("d123_data", 32'(ent.entry_data), 32'h0123);
        step(kb(11));
        chk("d123_valid", 32'(ent.entry_valid), 32'd1);
        repeat (5) step(16'h0);
        chk("d123_hold", 32'(ent.entry_data), 32'h0123);
        step(16'h0, 1'b1);
        chk("d123_acc", 32'(ent.entry_data), 32'h0);

        // Overflow on a fifth digit, then backspace and clear
        step(kb(9)); step(kb(8)); step(kb(7)); step(kb(6));
        chk("ovf_data", 32'(ent.entry_data), 32'h9876);
        step(kb(5));
        chk("ovf_err", 32'(err_pulse), 32'd1);
        step(kb(10));
        chk("bs_data", 32'(ent.entry_data), 32'h0987);
        step(kb(12));
        chk("clr_busy", 32'(busy), 32'd0);

        // Two keys in one cycle, then an ignored key
        step(16'h0006);
        chk("multi", 32'(ent.entry_data), 32'h0001);
        step(kb(14));
        chk("ign_err", 32'(err_pulse), 32'd0);
        step(kb(12));

        // Timeout fires exactly T cycles after the key
        step(kb(5));
        k = 0;
        for (int i = 1; i <= T + 5; i++) begin
            step(16'h0);
            if (timeout_pulse) begin k = i; break; end
        end
        chk("to_lat", 32'(k), 32'(T));
        // A digit on the expiry cycle keeps the entry alive
        step(kb(5));
        repeat (T - 1) step(16'h0);
        step(kb(3));
        chk("to_save", 32'(ent.entry_len), 32'd2);
        step(kb(12));

        // Enter while idle, then a digit while an entry is held
        step(kb(11));
        chk("ent_idle", 32'(err_pulse), 32'd1);
        step(kb(4)); step(kb(11)); step(kb(7));
        chk("hold_data", 32'(ent.entry_data), 32'h0004);

        // Reset while an entry is held
        step(16'h0, 1'b0, 1'b1);
        chk("rst_hold", 32'(busy), 32'd0);
        step(kb(2)); step(kb(11)); step(16'h0, 1'b1);

        // Random traffic; quiet phases give timeouts a chance to fire
        for (int c = 0; c < 4000; c++) begin
            bit quiet = ((c / 500) % 2) == 1;
            kp = '0;
            if ($urandom_range(0, 99) < (quiet ? 1 : 30)) begin
                if ($urandom_range(0, 1) == 0) kp = kb($urandom_range(0, 15));
                else kp = 16'($urandom());
            end
            step(kp, $urandom_range(0, 3) == 0, $urandom_range(0, 499) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
